// File: rtl/sseg_operand_decoder_if.sv
// Symbol-in / frame-out handshake bundle for the seven-segment operand decoder.
// master = symbol producer and frame consumer, slave = decoder.
interface sseg_operand_decoder_if #(
  parameter int W = 10
);
  logic         in_valid;
  logic         in_ready;
  logic [6:0]   seg_code;
  logic         seg_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] num1;
  logic [W-1:0] num2;
  logic         sig1;
  logic         sig2;
  logic [1:0]   oper;
  logic [1:0]   err;

  modport master (
    output in_valid, seg_code, seg_last, out_ready,
    input  in_ready, out_valid, num1, num2, sig1, sig2, oper, err
  );

  modport slave (
    input  in_valid, seg_code, seg_last, out_ready,
    output in_ready, out_valid, num1, num2, sig1, sig2, oper, err
  );
endinterface

// File: rtl/sseg_operand_decoder.sv
// Parses a stream of seven-segment symbols "[-]digits op [-]digits" into two
// signed-magnitude operands and an operator, holding the result until consumed.
module sseg_operand_decoder #(
  parameter int NDIG = 3,
  parameter int W    = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sseg_operand_decoder_if.slave bus
);
  localparam int CW = $clog2(NDIG + 2);

  typedef enum logic [2:0] {S_SIGN1, S_DIG1, S_SIGN2, S_DIG2, S_ERR, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  acc1_q, acc1_d, acc2_q, acc2_d;
  logic          sig1_q, sig1_d, sig2_q, sig2_d;
  logic [1:0]    oper_q, oper_d, err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d, in_ready_q, in_ready_d;

  logic          is_dig, is_blank, is_minus, is_op;
  logic [3:0]    dig;
  logic [1:0]    op_code, err_code;
  logic          in_op2;
  logic [W-1:0]  acc_sel;
  logic [W+3:0]  acc_next;
  logic [CW-1:0] cnt_next;

  always_comb begin
    is_dig = 1'b0; is_blank = 1'b0; is_minus = 1'b0; is_op = 1'b0;
    dig = 4'd0; op_code = 2'd0;
    case (bus.seg_code)
      7'b0000001: begin is_dig = 1'b1; dig = 4'd0; end
      7'b1001111: begin is_dig = 1'b1; dig = 4'd1; end
      7'b0010010: begin is_dig = 1'b1; dig = 4'd2; end
      7'b0000110: begin is_dig = 1'b1; dig = 4'd3; end
      7'b1001100: begin is_dig = 1'b1; dig = 4'd4; end
      7'b0100100: begin is_dig = 1'b1; dig = 4'd5; end
      7'b0100000: begin is_dig = 1'b1; dig = 4'd6; end
      7'b0001111: begin is_dig = 1'b1; dig = 4'd7; end
      7'b0000000: begin is_dig = 1'b1; dig = 4'd8; end
      7'b0000100: begin is_dig = 1'b1; dig = 4'd9; end
      7'b1111110: begin is_minus = 1'b1; is_op = 1'b1; op_code = 2'd1; end
      7'b1101100: begin is_op = 1'b1; op_code = 2'd0; end
      7'b1001000: begin is_op = 1'b1; op_code = 2'd2; end
      7'b1011011: begin is_op = 1'b1; op_code = 2'd3; end
      7'b1111111: is_blank = 1'b1;
      default: ;
    endcase
  end

  // Accumulators are zero in the SIGN states, so one multiply-add serves the first digit too.
  assign in_op2   = (state_q == S_SIGN2) || (state_q == S_DIG2);
  assign acc_sel  = in_op2 ? acc2_q : acc1_q;
  assign acc_next = {4'd0, acc_sel} * (W+4)'(10) + (W+4)'(dig);
  assign cnt_next = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q; acc1_d = acc1_q; acc2_d = acc2_q;
    sig1_d = sig1_q; sig2_d = sig2_q; oper_d = oper_q; err_d = err_q; cnt_d = cnt_q;
    err_code = 2'd0;
    if (state_q == S_DONE) begin
      if (bus.out_ready) begin
        state_d = S_SIGN1; acc1_d = '0; acc2_d = '0; sig1_d = 1'b0; sig2_d = 1'b0;
        oper_d = 2'd0; err_d = 2'd0; cnt_d = '0;
      end
    end else if (bus.in_valid && in_ready_q) begin
      if (is_blank) begin
        // A trailing blank closes the frame using whatever the previous symbol left behind.
        if (bus.seg_last) begin
          if (state_q == S_ERR || (state_q == S_DIG2 && cnt_q != '0)) state_d = S_DONE;
          else err_code = 2'd1;
        end
      end else if (state_q == S_ERR) begin
        if (bus.seg_last) state_d = S_DONE;
      end else begin
        if (is_dig) begin
          if (cnt_next > CW'(NDIG))        err_code = 2'd2;
          else if (acc_next[W+3:W] != '0)  err_code = 2'd3;
          else begin
            cnt_d = cnt_next;
            if (in_op2) acc2_d = acc_next[W-1:0];
            else        acc1_d = acc_next[W-1:0];
            state_d = in_op2 ? S_DIG2 : S_DIG1;
          end
        end else if (is_minus && (state_q == S_SIGN1 || state_q == S_SIGN2)) begin
          if (in_op2) sig2_d = 1'b1;
          else        sig1_d = 1'b1;
          state_d = in_op2 ? S_DIG2 : S_DIG1;
        end else if (is_op && state_q == S_DIG1 && cnt_q != '0) begin
          oper_d = op_code; cnt_d = '0; state_d = S_SIGN2;
        end else begin
          err_code = 2'd1;
        end
        // Only a digit of the second operand may close a frame.
        if (bus.seg_last && err_code == 2'd0) begin
          if (is_dig && in_op2) state_d = S_DONE;
          else                  err_code = 2'd1;
        end
      end
      if (err_code != 2'd0) begin
        err_d = err_code; acc1_d = '0; acc2_d = '0; sig1_d = 1'b0; sig2_d = 1'b0;
        oper_d = 2'd0; cnt_d = '0;
        state_d = bus.seg_last ? S_DONE : S_ERR;
      end
    end
    out_valid_d = (state_d == S_DONE);
    in_ready_d  = (state_d != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_SIGN1; acc1_q <= '0; acc2_q <= '0; sig1_q <= 1'b0; sig2_q <= 1'b0;
      oper_q <= 2'd0; err_q <= 2'd0; cnt_q <= '0;
      out_valid_q <= 1'b0; in_ready_q <= 1'b1;
    end else begin
      state_q <= state_d; acc1_q <= acc1_d; acc2_q <= acc2_d; sig1_q <= sig1_d; sig2_q <= sig2_d;
      oper_q <= oper_d; err_q <= err_d; cnt_q <= cnt_d;
      out_valid_q <= out_valid_d; in_ready_q <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.num1      = acc1_q;
  assign bus.num2      = acc2_q;
  assign bus.sig1      = sig1_q;
  assign bus.sig2      = sig2_q;
  assign bus.oper      = oper_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_sseg_operand_decoder.sv
// Drives one symbol stream into a W=10 and a W=8 decoder and scoreboards each frame.
module tb_sseg_operand_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0;
  logic [6:0] seg_code = 7'b1111111;
  logic       seg_last = 1'b0;
  logic       out_ready = 1'b1;

  sseg_operand_decoder_if #(.W(10)) b10();
  sseg_operand_decoder_if #(.W(8))  b8();

  assign b10.in_valid = in_valid; assign b10.seg_code = seg_code;
  assign b10.seg_last = seg_last; assign b10.out_ready = out_ready;
  assign b8.in_valid  = in_valid; assign b8.seg_code  = seg_code;
  assign b8.seg_last  = seg_last; assign b8.out_ready  = out_ready;

  sseg_operand_decoder #(.NDIG(3), .W(10)) u10 (.clk(clk), .rst_n(rst_n), .bus(b10.slave));
  sseg_operand_decoder #(.NDIG(3), .W(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

  localparam logic [6:0] SD [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                      7'b0000000, 7'b0000100};
  localparam logic [6:0] MIN = 7'b1111110, PLS = 7'b1101100, DIV = 7'b1011011;
  localparam logic [6:0] MUL = 7'b1001000, BLK = 7'b1111111, BAD = 7'b0101010;

  typedef struct packed {
    logic [9:0] n1, n2;
    logic       s1, s2;
    logic [1:0] op, er;
  } exp_t;

  exp_t q10[$];
  exp_t q8[$];
  int tests = 0;
  int fails = 0;

  function automatic exp_t mk(int n1, int n2, int s1, int s2, int op, int er);
    exp_t e;
    e.n1 = 10'(n1); e.n2 = 10'(n2); e.s1 = s1[0]; e.s2 = s2[0]; e.op = 2'(op); e.er = 2'(er);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input exp_t e10, input exp_t e8);
    q10.push_back(e10);
    q8.push_back(e8);
  endtask

  task automatic send(input logic [6:0] c, input logic l);
    int g = 0;
    while (!b10.in_ready && g < 20) begin @(posedge clk); #1; g++; end
    if (g >= 20) chk("in_ready_timeout", b10.in_ready, 1);
    if (l) chk("no_early_valid", b10.out_valid, 0);
    in_valid = 1'b1; seg_code = c; seg_last = l;
    @(posedge clk); #1;
    in_valid = 1'b0; seg_last = 1'b0; seg_code = BLK;
  endtask

  task automatic collect(input string tag);
    exp_t e;
    int g = 0;
    while (!b10.out_valid && g < 20) begin @(posedge clk); #1; g++; end
    chk({tag, "_latency"}, g, 0);
    chk({tag, "_ov8"}, b8.out_valid, 1);
    chk({tag, "_sb10"}, q10.size(), 1);
    chk({tag, "_sb8"}, q8.size(), 1);
    if (q10.size() > 0 && q8.size() > 0) begin
      e = q10.pop_front();
      chk({tag, "_num1"}, b10.num1, e.n1); chk({tag, "_num2"}, b10.num2, e.n2);
      chk({tag, "_sig1"}, b10.sig1, e.s1); chk({tag, "_sig2"}, b10.sig2, e.s2);
      chk({tag, "_oper"}, b10.oper, e.op); chk({tag, "_err"}, b10.err, e.er);
      e = q8.pop_front();
      chk({tag, "_w8_num1"}, b8.num1, e.n1); chk({tag, "_w8_num2"}, b8.num2, e.n2);
      chk({tag, "_w8_sig"}, {b8.sig1, b8.sig2}, {e.s1, e.s2});
      chk({tag, "_w8_oper"}, b8.oper, e.op); chk({tag, "_w8_err"}, b8.err, e.er);
    end
  endtask

  task automatic release_chk(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_ov_drop"}, b10.out_valid, 0);
    chk({tag, "_in_ready"}, b10.in_ready, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", b10.out_valid, 0);
    chk("rst_in_ready", b10.in_ready, 1);
    chk("rst_nums", {b10.num1, b10.num2}, 0);
    chk("rst_flags", {b10.sig1, b10.sig2, b10.oper, b10.err}, 0);
    chk("rst_w8", {b8.out_valid, b8.num1, b8.err}, 0);
    rst_n = 1'b1;

    // 123 + 45
    push(mk(123, 45, 0, 0, 0, 0), mk(123, 45, 0, 0, 0, 0));
    send(SD[1], 0); send(SD[2], 0); send(SD[3], 0); send(PLS, 0); send(SD[4], 0); send(SD[5], 1);
    collect("add"); release_chk("add");

    // -7 / -9
    push(mk(7, 9, 1, 1, 3, 0), mk(7, 9, 1, 1, 3, 0));
    send(MIN, 0); send(SD[7], 0); send(DIV, 0); send(MIN, 0); send(SD[9], 1);
    collect("div"); release_chk("div");

    // same with blanks everywhere
    push(mk(7, 9, 1, 1, 3, 0), mk(7, 9, 1, 1, 3, 0));
    send(BLK, 0); send(MIN, 0); send(BLK, 0); send(SD[7], 0); send(BLK, 0); send(DIV, 0);
    send(BLK, 0); send(MIN, 0); send(BLK, 0); send(SD[9], 1);
    collect("blanks"); release_chk("blanks");

    // too many digits
    push(mk(0, 0, 0, 0, 0, 2), mk(0, 0, 0, 0, 0, 2));
    send(SD[1], 0); send(SD[2], 0); send(SD[3], 0); send(SD[4], 0); send(MUL, 0); send(SD[5], 1);
    collect("ndig"); release_chk("ndig");

    // bad symbol mid-frame; later symbols must not replace the first error
    push(mk(0, 0, 0, 0, 0, 1), mk(0, 0, 0, 0, 0, 1));
    send(SD[1], 0); send(BAD, 0); send(SD[2], 0); send(SD[3], 0); send(SD[4], 0); send(SD[3], 1);
    collect("bad"); release_chk("bad");

    // frame ending on the operator
    push(mk(0, 0, 0, 0, 0, 1), mk(0, 0, 0, 0, 0, 1));
    send(SD[1], 0); send(PLS, 1);
    collect("oplast"); release_chk("oplast");

    // 300 fits W=10 but overflows W=8
    push(mk(300, 1, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 3));
    send(SD[3], 0); send(SD[0], 0); send(SD[0], 0); send(PLS, 0); send(SD[1], 1);
    collect("ovf"); release_chk("ovf");

    // 8 * 42 closed by a trailing blank
    push(mk(8, 42, 0, 0, 2, 0), mk(8, 42, 0, 0, 2, 0));
    send(SD[8], 0); send(MUL, 0); send(SD[4], 0); send(SD[2], 0); send(BLK, 1);
    collect("blklast"); release_chk("blklast");

    // backpressure in DONE, then a back-to-back frame
    out_ready = 1'b0;
    push(mk(99, 11, 0, 0, 1, 0), mk(99, 11, 0, 0, 1, 0));
    send(SD[9], 0); send(SD[9], 0); send(MIN, 0); send(SD[1], 0); send(SD[1], 1);
    collect("hold");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_ov", b10.out_valid, 1);
      chk("hold_in_ready", b10.in_ready, 0);
      chk("hold_data", {b10.num1, b10.num2, b10.oper, b10.err}, {10'd99, 10'd11, 2'd1, 2'd0});
    end
    release_chk("hold");
    push(mk(5, 67, 0, 1, 0, 0), mk(5, 67, 0, 1, 0, 0));
    send(SD[5], 0); send(PLS, 0); send(MIN, 0); send(SD[6], 0); send(SD[7], 1);
    collect("b2b"); release_chk("b2b");

    // reset mid-frame discards the partial frame
    send(SD[1], 0); send(SD[2], 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_num1", b10.num1, 0);
    chk("midrst_in_ready", b10.in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_valid", b10.out_valid, 0);
    end
    push(mk(42, 7, 0, 0, 3, 0), mk(42, 7, 0, 0, 3, 0));
    send(SD[4], 0); send(SD[2], 0); send(DIV, 0); send(SD[7], 1);
    collect("postrst"); release_chk("postrst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
